// File: rtl/demux_reg_array.sv
// Registered 1-to-NUM_OUT demultiplexer: one input word per cycle is steered into a
// one-entry holding register per output, each draining through its own valid/ready pair.
module demux_reg_array #(
  parameter int SIZE      = 16,
  parameter int NUM_OUT   = 4,
  parameter int SEL_WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SEL_WIDTH-1:0]      sel,
  input  logic [SIZE-1:0]           in_data,
  output logic [NUM_OUT-1:0]        out_valid,
  input  logic [NUM_OUT-1:0]        out_ready,
  output logic [NUM_OUT*SIZE-1:0]   out_data,
  output logic [7:0]                drop_count
);

  // One extra bit so NUM_OUT == 2**SEL_WIDTH is representable.
  localparam logic [SEL_WIDTH:0] NUM_OUT_W = (SEL_WIDTH + 1)'(NUM_OUT);

  logic                 w_sel_legal;
  logic [NUM_OUT-1:0]   w_sel_hot;
  logic [NUM_OUT-1:0]   w_load;
  logic [NUM_OUT-1:0]   w_drain;
  logic                 w_accept;
  logic                 w_drop;

  logic [NUM_OUT-1:0]   r_valid;
  logic [SIZE-1:0]      r_data [NUM_OUT];
  logic [7:0]           r_drop_count;

  assign w_sel_legal = ({1'b0, sel} < NUM_OUT_W);

  generate
    for (genvar i = 0; i < NUM_OUT; i++) begin : g_hot
      localparam logic [SEL_WIDTH-1:0] IDX = SEL_WIDTH'(i);
      assign w_sel_hot[i] = (sel == IDX);
    end
  endgenerate

  // An out-of-range sel selects no output, so the word is always taken and dropped.
  assign in_ready = ~|(w_sel_hot & r_valid & ~out_ready);
  assign w_accept = in_valid & in_ready;
  assign w_load   = w_sel_hot & {NUM_OUT{w_accept}};
  assign w_drain  = r_valid & out_ready;
  assign w_drop   = w_accept & ~w_sel_legal;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order within or across blocks.
  // NOTE: the holding registers are reset along with their flags because the
  // reset value of out_data is observable on the ports.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_valid <= '0;
      for (int i = 0; i < NUM_OUT; i++) r_data[i] <= '0;
    end else begin
      // A refill in the same cycle as a drain keeps the flag set with no bubble.
      r_valid <= w_load | (r_valid & ~w_drain);
      for (int i = 0; i < NUM_OUT; i++) begin
        if (w_load[i]) r_data[i] <= in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_drop_count <= '0;
    end else if (w_drop && (r_drop_count != 8'hFF)) begin
      r_drop_count <= r_drop_count + 8'd1;
    end
  end

  assign out_valid  = r_valid;
  assign drop_count = r_drop_count;

  generate
    for (genvar i = 0; i < NUM_OUT; i++) begin : g_out
      assign out_data[i*SIZE +: SIZE] = r_data[i];

      a_hold_until_drain : assert property (@(posedge clk) disable iff (!reset_n)
        (r_valid[i] && !out_ready[i]) |=> (r_valid[i] && $stable(r_data[i])));
    end
  endgenerate

  a_drop_saturates : assert property (@(posedge clk) disable iff (!reset_n)
    (r_drop_count == 8'hFF) |=> (r_drop_count == 8'hFF));

endmodule
